coherence_bus_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the shared MSI snooping bus. Grants one cache

---
 rtl/coherence_bus_arbiter.sv | 159 +++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherence_bus_arbiter.sv
// Round-robin owner selection for the shared MSI snooping bus: broadcasts the owner's
// message, then sequences any snooper write-back and the line fetch before releasing the bus.
module coherence_bus_arbiter #(
  parameter int NUM_CPU = 4,
  parameter int ADDR_W  = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CPU-1:0]        req,
  input  logic [2*NUM_CPU-1:0]      req_msg,
  input  logic [ADDR_W*NUM_CPU-1:0] req_addr,
  input  logic [NUM_CPU-1:0]        snoop_wb,
  input  logic                      mem_ack,
  output logic [NUM_CPU-1:0]        grant,
  output logic [NUM_CPU-1:0]        done,
  output logic                      bus_valid,
  output logic [1:0]                bus_msg,
  output logic [ADDR_W-1:0]         bus_addr,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      wb_conflict,
  output logic [2:0]                debug_state
);

  localparam int         IDX_W   = $clog2(NUM_CPU);
  localparam logic [1:0] MSG_INV = 2'b10;
  localparam logic [1:0] MSG_NA  = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_BCAST, S_WB, S_FETCH, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [1:0]          msg_q, msg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                conflict_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [1:0]          pick_msg;
  logic [ADDR_W-1:0]   pick_addr;
  logic [NUM_CPU-1:0]  wb_masked;

  logic [NUM_CPU-1:0]  owner_oh;
  logic [NUM_CPU-1:0]  grant_d, done_d;
  logic                bus_valid_d, mem_req_d, mem_we_d;
  logic [1:0]          bus_msg_d;
  logic [ADDR_W-1:0]   bus_addr_d;

  // First requester at or after the round-robin pointer, wrapping around.
  always_comb begin : arb_pick
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_CPU; k++) begin
      cand = (int'(ptr_q) + k) % NUM_CPU;
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign pick_msg  = req_msg[2*int'(pick_idx) +: 2];
  assign pick_addr = req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];

  // The owner's own snooper never supplies the line to itself.
  assign wb_masked = snoop_wb & ~grant;

  always_comb begin : fsm_next
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    msg_d      = msg_q;
    addr_d     = addr_q;
    conflict_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d = pick_idx;
          msg_d   = pick_msg;
          addr_d  = pick_addr;
          state_d = (pick_msg == MSG_NA) ? S_DONE : S_BCAST;
        end
      end
      S_BCAST: begin
        if (msg_q == MSG_INV) begin
          state_d = S_DONE;
        end else if (|wb_masked) begin
          state_d    = S_WB;
          conflict_d = ($countones(wb_masked) > 1);
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB: begin
        if (mem_ack) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
        ptr_d   = (int'(owner_q) == NUM_CPU - 1) ? '0 : owner_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin : out_next
    owner_oh    = NUM_CPU'(1) << owner_d;
    grant_d     = (state_d == S_IDLE) ? '0 : owner_oh;
    done_d      = (state_d == S_DONE) ? owner_oh : '0;
    bus_valid_d = (state_d == S_BCAST);
    bus_msg_d   = (state_d == S_BCAST) ? msg_d : MSG_NA;
    bus_addr_d  = (state_d == S_BCAST) ? addr_d : '0;
    mem_req_d   = (state_d == S_WB) || (state_d == S_FETCH);
    mem_we_d    = (state_d == S_WB);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      msg_q       <= MSG_NA;
      addr_q      <= '0;
      grant       <= '0;
      done        <= '0;
      bus_valid   <= 1'b0;
      bus_msg     <= MSG_NA;
      bus_addr    <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      wb_conflict <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      msg_q       <= msg_d;
      addr_q      <= addr_d;
      grant       <= grant_d;
      done        <= done_d;
      bus_valid   <= bus_valid_d;
      bus_msg     <= bus_msg_d;
      bus_addr    <= bus_addr_d;
      mem_req     <= mem_req_d;
      mem_we      <= mem_we_d;
      wb_conflict <= conflict_d;
    end
  end

  assign mem_addr    = addr_q;
  assign debug_state = state_q;

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Bench for coherence_bus_arbiter: rounds of held requests are predicted in round-robin
// order into a queue; a negedge monitor follows each granted transaction and compares.
module tb_coherence_bus_arbiter;
  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int REC_W = 3 + 2 + AW + N;
  localparam logic [1:0] M_WM  = 2'b00;
  localparam logic [1:0] M_RM  = 2'b01;
  localparam logic [1:0] M_INV = 2'b10;
  localparam logic [1:0] M_NA  = 2'b11;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n  = 1'b0;
  logic [N-1:0]      req      = '0;
  logic [2*N-1:0]    req_msg  = '1;
  logic [AW*N-1:0]   req_addr = '0;
  logic [N-1:0]      snoop_wb = '0;
  logic              mem_ack  = 1'b0;
  logic [N-1:0]      grant, done;
  logic              bus_valid, mem_req, mem_we, wb_conflict;
  logic [1:0]        bus_msg;
  logic [AW-1:0]     bus_addr, mem_addr;
  logic [2:0]        debug_state;

  coherence_bus_arbiter #(.NUM_CPU(N), .ADDR_W(AW)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_msg(req_msg), .req_addr(req_addr),
    .snoop_wb(snoop_wb), .mem_ack(mem_ack), .grant(grant), .done(done),
    .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_addr(bus_addr), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .wb_conflict(wb_conflict), .debug_state(debug_state)
  );

  int checks = 0;
  int errors = 0;
  logic [REC_W-1:0] exp_q[$];
  logic [N-1:0]     wb_q[$];
  int  model_ptr = 0;
  bit  mem_hold  = 1'b0;
  logic rst_s    = 1'b0;
  always @(posedge clock) rst_s <= reset_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- responders ----------------
  always @(posedge clock) begin
    #1;
    if (mem_req && !mem_hold) mem_ack = ($urandom_range(0, 2) == 0);
    else                      mem_ack = !mem_req && ($urandom_range(0, 7) == 0);
  end

  always @(posedge clock) begin
    #1;
    if (bus_valid) begin
      if (wb_q.size() != 0) snoop_wb = wb_q.pop_front();
      else                  snoop_wb = '0;
    end else begin
      snoop_wb = N'($urandom);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef enum logic [1:0] {P_BCAST, P_WB, P_FETCH, P_DONE} phase_t;
  phase_t           ph = P_DONE;
  bit               in_txn = 0, gap = 0, pend = 0, first_wb = 0, conflict_exp = 0;
  logic [REC_W-1:0] cur;
  logic [2:0]       c_owner;
  logic [1:0]       c_msg;
  logic [AW-1:0]    c_addr;
  logic [N-1:0]     c_wb, c_oh, c_masked;

  always @(negedge clock) begin
    if (!rst_s) begin
      check("reset_outputs", {grant, done, bus_valid, bus_msg, bus_addr, mem_req, mem_we, wb_conflict},
            {4'h0, 4'h0, 1'b0, 2'b11, 8'h00, 3'b000});
      check("reset_mem_addr", mem_addr, 0);
      in_txn = 0;
      gap    = 0;
      pend   = reset_n && (req != 0);
    end else begin
      if (pend) check("grant_latency", grant != 0, 1);
      if (!in_txn && !gap && grant != 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %0h expected none at %0t", grant, $time);
        end else begin
          cur = exp_q.pop_front();
          {c_owner, c_msg, c_addr, c_wb} = cur;
          c_oh         = N'(1) << c_owner;
          c_masked     = c_wb & ~c_oh;
          conflict_exp = ($countones(c_masked) > 1);
          ph           = (c_msg == M_NA) ? P_DONE : P_BCAST;
          first_wb     = 1;
          in_txn       = 1;
        end
      end
      if (in_txn) begin
        pend = 0;
        check("grant_owner", grant, c_oh);
        case (ph)
          P_BCAST: begin
            check("bcast_valid", bus_valid, 1);
            check("bcast_msg", bus_msg, c_msg);
            check("bcast_addr", bus_addr, c_addr);
            check("bcast_quiet", {mem_req, done, wb_conflict}, 0);
            if (c_msg == M_INV)     ph = P_DONE;
            else if (c_masked != 0) ph = P_WB;
            else                    ph = P_FETCH;
          end
          P_WB: begin
            check("wb_bus", {bus_valid, bus_msg, bus_addr}, {1'b0, 2'b11, 8'h00});
            check("wb_mem", {mem_req, mem_we, done}, {2'b11, 4'h0});
            check("wb_addr", mem_addr, c_addr);
            check("wb_conflict", wb_conflict, first_wb && conflict_exp);
            first_wb = 0;
            if (mem_ack) ph = P_FETCH;
          end
          P_FETCH: begin
            check("fetch_bus", {bus_valid, bus_msg, bus_addr}, {1'b0, 2'b11, 8'h00});
            check("fetch_mem", {mem_req, mem_we, done, wb_conflict}, {2'b10, 4'h0, 1'b0});
            check("fetch_addr", mem_addr, c_addr);
            if (mem_ack) ph = P_DONE;
          end
          default: begin
            check("done_pulse", done, c_oh);
            check("done_quiet", {bus_valid, mem_req, wb_conflict}, 0);
            in_txn = 0;
            gap    = 1;
          end
        endcase
      end else begin
        check("idle_outputs", {grant, done, bus_valid, bus_msg, bus_addr, mem_req, wb_conflict},
              {4'h0, 4'h0, 1'b0, 2'b11, 8'h00, 2'b00});
        gap  = 0;
        pend = reset_n && (req != 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_round(input logic [N-1:0] mask, input logic [2*N-1:0] msgs,
                           input logic [AW*N-1:0] addrs, input logic [N*N-1:0] wbs);
    int last;
    int cyc;
    last = -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (model_ptr + k) % N;
      if (mask[i]) begin
        exp_q.push_back({3'(i), msgs[2*i +: 2], addrs[AW*i +: AW], wbs[N*i +: N]});
        if (msgs[2*i +: 2] != M_NA) wb_q.push_back(wbs[N*i +: N]);
        last = i;
      end
    end
    if (last >= 0) model_ptr = (last + 1) % N;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        req_msg[2*i +: 2]   = msgs[2*i +: 2];
        req_addr[AW*i +: AW] = addrs[AW*i +: AW];
      end
    end
    req = mask;
    cyc = 0;
    while ((req != 0 || grant != 0) && cyc < 400) begin
      @(posedge clock);
      #1;
      cyc++;
      for (int i = 0; i < N; i++) begin
        if (done[i]) req[i] = 1'b0;
        else if (grant[i] && $urandom_range(0, 5) == 0) req[i] = 1'b0;
        if (!req[i] || grant[i]) begin
          req_msg[2*i +: 2]   = 2'($urandom);
          req_addr[AW*i +: AW] = AW'($urandom);
        end
      end
    end
    checks++;
    if (cyc >= 400) begin
      errors++;
      $display("FAIL round_timeout: got %0d cycles expected under 400, req %0h grant %0h", cyc, req, grant);
      req = '0;
    end
  endtask

  task automatic reset_mid_wb();
    int cyc;
    mem_hold = 1'b1;
    exp_q.push_back({3'd2, M_RM, 8'h40, 4'b0010});
    wb_q.push_back(4'b0010);
    req_msg[5:4]   = M_RM;
    req_addr[23:16] = 8'h40;
    req = 4'b0100;
    cyc = 0;
    do begin
      @(posedge clock);
      #1;
      cyc++;
    end while (!(mem_req && mem_we) && cyc < 50);
    check("reach_wb", {mem_req, mem_we}, 2'b11);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    req     = '0;
    @(posedge clock);
    #1;
    reset_n  = 1'b1;
    mem_hold = 1'b0;
    exp_q.delete();
    wb_q.delete();
    model_ptr = 0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [N-1:0]    r_mask;
    logic [2*N-1:0]  r_msgs;
    logic [AW*N-1:0] r_addrs;
    logic [N*N-1:0]  r_wbs;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;
    idle_cycles(2);

    run_round(4'b0001, 8'b11_11_11_10, 32'h0000_0012, 16'h0000);
    run_round(4'b0100, 8'b11_01_11_11, 32'h0040_0000, 16'h0200);
    run_round(4'b0010, 8'b11_11_00_11, 32'h0000_5500, 16'h0000);
    run_round(4'b0001, 8'b11_11_11_01, 32'h0000_00A0, 16'h0006);
    run_round(4'b0001, 8'b11_11_11_00, 32'h0000_00A1, 16'h0001);
    idle_cycles(1);
    reset_mid_wb();
    idle_cycles(2);
    run_round(4'b1111, 8'hFF, 32'h1122_3344, 16'h0000);

    for (int r = 0; r < 60; r++) begin
      r_mask  = N'($urandom);
      r_msgs  = (2*N)'($urandom);
      r_addrs = $urandom;
      for (int i = 0; i < N; i++)
        r_wbs[N*i +: N] = ($urandom_range(0, 1) == 1) ? N'($urandom) : '0;
      run_round(r_mask, r_msgs, r_addrs, r_wbs);
      idle_cycles($urandom_range(0, 3));
    end

    idle_cycles(4);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
